// File: rtl/sha256_stream_core_if.sv
// ---------------------------------------------------------------------------
// sha256_stream_core_if
// Handshake bundle between the SHA-256 streaming engine and its neighbours.
//   blk_valid/blk_ready        : block input handshake
//   blk_data/blk_first/blk_last: padded 512-bit block and message framing
//   digest_valid/digest_ready  : digest output handshake
//   digest                     : {H0..H7} of the finished message
//   busy                       : engine is working on or holding a block
//   mode_224                   : only with SHA256_STREAM_SHA224_EN defined
// Modports: slave = engine side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface sha256_stream_core_if;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;
   logic         digest_valid;
   logic         digest_ready;
   logic [255:0] digest;
   logic         busy;
`ifdef SHA256_STREAM_SHA224_EN
   logic         mode_224;
`endif

   modport slave (
      input  blk_valid, blk_data, blk_first, blk_last, digest_ready,
`ifdef SHA256_STREAM_SHA224_EN
      input  mode_224,
`endif
      output blk_ready, digest_valid, digest, busy
   );

   modport master (
      output blk_valid, blk_data, blk_first, blk_last, digest_ready,
`ifdef SHA256_STREAM_SHA224_EN
      output mode_224,
`endif
      input  blk_ready, digest_valid, digest, busy
   );
endinterface

// File: rtl/sha256_stream_core.sv
// ---------------------------------------------------------------------------
// sha256_stream_core
// Multi-block SHA-256 compression engine. Accepts pre-padded 512-bit blocks
// over a valid/ready handshake, chains H across the blocks of a message and
// presents one back-pressured 256-bit digest per message. The message
// schedule is produced on the fly from a 16-word sliding window.
// Parameter:
//   ROUNDS_PER_CYCLE : rounds applied per clock (1, 2, 4 or 8)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   s   : sha256_stream_core_if.slave (block input, digest output, busy)
// Optional feature macro: SHA256_STREAM_SHA224_EN adds s.mode_224, which
// selects the SHA-224 IV and truncated digest on a blk_first handshake.
// ---------------------------------------------------------------------------
module sha256_stream_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input logic                 clk,
   input logic                 rst,
   sha256_stream_core_if.slave s
);
   localparam int R = ROUNDS_PER_CYCLE;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
`ifdef SHA256_STREAM_SHA224_EN
   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };
`endif

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

   state_t       state_reg;
   logic [31:0]  h_reg    [8];
   logic [31:0]  work_reg [8];
   logic [31:0]  win_reg  [16];   // W[t..t+15]
   logic [5:0]   t_reg;
   logic         last_reg;
   logic         blk_ready_reg;
   logic         busy_reg;
   logic         digest_valid_reg;
   logic [255:0] digest_reg;
`ifdef SHA256_STREAM_SHA224_EN
   logic         mode_reg;
`endif

   logic [31:0]  blk_word  [16];
   logic [31:0]  k_sel     [R];
   logic [31:0]  iv_sel    [8];
   logic [31:0]  h_sum     [8];
   logic [31:0]  work_next [8];
   logic [31:0]  win_next  [16];
   logic [255:0] digest_value;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   for (genvar gi = 0; gi < 16; gi++) begin : g_word
      assign blk_word[gi] = s.blk_data[511 - 32*gi -: 32];
   end

   // t is always a multiple of R, so t+gi never passes 63
   for (genvar gi = 0; gi < R; gi++) begin : g_k
      assign k_sel[gi] = K[t_reg + 6'(gi)];
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_h
      assign h_sum[gi] = h_reg[gi] + work_reg[gi];
`ifdef SHA256_STREAM_SHA224_EN
      assign iv_sel[gi] = s.mode_224 ? IV224[gi] : IV256[gi];
`else
      assign iv_sel[gi] = IV256[gi];
`endif
   end

`ifdef SHA256_STREAM_SHA224_EN
   assign digest_value = mode_reg ?
      {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4], h_sum[5], h_sum[6], 32'h0} :
      {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
`else
   assign digest_value = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
`endif

   // ext[0..15] is the current window, ext[16..] are the R words that slide
   // in next; words past W63 are computed but never consumed.
   always_comb begin : round_comb
      logic [31:0] ext [16+R];
      logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2;
      for (int i = 0; i < 16; i++) ext[i] = win_reg[i];
      for (int i = 16; i < 16 + R; i++)
         ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
      for (int i = 0; i < 16; i++) win_next[i] = ext[i+R];
      va = work_reg[0]; vb = work_reg[1]; vc = work_reg[2]; vd = work_reg[3];
      ve = work_reg[4]; vf = work_reg[5]; vg = work_reg[6]; vh = work_reg[7];
      t1 = '0;
      t2 = '0;
      for (int j = 0; j < R; j++) begin
         t1 = vh + bsig1(ve) + ((ve & vf) ^ (~ve & vg)) + k_sel[j] + ext[j];
         t2 = bsig0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));
         vh = vg; vg = vf; vf = ve; ve = vd + t1;
         vd = vc; vc = vb; vb = va; va = t1 + t2;
      end
      work_next[0] = va; work_next[1] = vb; work_next[2] = vc; work_next[3] = vd;
      work_next[4] = ve; work_next[5] = vf; work_next[6] = vg; work_next[7] = vh;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         t_reg            <= '0;
         last_reg         <= 1'b0;
         blk_ready_reg    <= 1'b1;
         busy_reg         <= 1'b0;
         digest_valid_reg <= 1'b0;
         digest_reg       <= '0;
`ifdef SHA256_STREAM_SHA224_EN
         mode_reg         <= 1'b0;
`endif
         for (int i = 0; i < 8; i++) begin
            h_reg[i]    <= IV256[i];
            work_reg[i] <= '0;
         end
         for (int i = 0; i < 16; i++) win_reg[i] <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (s.blk_valid && blk_ready_reg) begin
                  for (int i = 0; i < 16; i++) win_reg[i] <= blk_word[i];
                  for (int i = 0; i < 8; i++) begin
                     if (s.blk_first) begin
                        work_reg[i] <= iv_sel[i];
                        h_reg[i]    <= iv_sel[i];
                     end else begin
                        work_reg[i] <= h_reg[i];
                     end
                  end
`ifdef SHA256_STREAM_SHA224_EN
                  if (s.blk_first) mode_reg <= s.mode_224;
`endif
                  last_reg      <= s.blk_last;
                  t_reg         <= '0;
                  blk_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= ROUND;
               end
            end
            ROUND: begin
               work_reg <= work_next;
               win_reg  <= win_next;
               t_reg    <= t_reg + 6'(R);
               if (t_reg == 6'(64 - R)) state_reg <= FINAL;
            end
            FINAL: begin
               h_reg <= h_sum;
               if (last_reg) begin
                  digest_reg       <= digest_value;
                  digest_valid_reg <= 1'b1;
                  state_reg        <= OUT;
               end else begin
                  blk_ready_reg <= 1'b1;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            OUT: begin
               if (s.digest_ready) begin
                  digest_valid_reg <= 1'b0;
                  blk_ready_reg    <= 1'b1;
                  busy_reg         <= 1'b0;
                  state_reg        <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign s.blk_ready    = blk_ready_reg;
   assign s.busy         = busy_reg;
   assign s.digest_valid = digest_valid_reg;
   assign s.digest       = digest_reg;
endmodule

// File: tb/tb_sha256_stream_core.sv
// ---------------------------------------------------------------------------
// tb_sha256_stream_core
// Scoreboard bench: stimulus pushes expected digests into a queue, a monitor
// pops them whenever a digest is transferred. Expected values are known
// test vectors or a textbook SHA-256 model. Four extra instances check the
// "abc" latency for R = 1, 2, 4 and 8.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha256_stream_core;
   localparam int R   = 2;
   localparam int LAT = 64 / R + 2;

   localparam logic [255:0] ABC_D    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_D  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_D    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] ABC224_D = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
   localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef logic [511:0] blk_t;
   typedef blk_t         bl_t [$];
   typedef byte unsigned bq_t [$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sha256_stream_core_if bus();
   logic dr_var   = 1'b1;
   int   dr_mode  = 0;     // 0: ready high, 1: ready low, 2: random
   bit   mode_sel = 1'b0;
   assign bus.digest_ready = dr_var;

   sha256_stream_core #(.ROUNDS_PER_CYCLE(R)) dut (.clk(clk), .rst(rst), .s(bus));

   always @(posedge clk) begin
      #1;
      if (dr_mode == 0)      dr_var = 1'b1;
      else if (dr_mode == 1) dr_var = 1'b0;
      else                   dr_var = 1'($urandom_range(0, 1));
   end

   // ---------------- latency instances, R = 1, 2, 4, 8 ----------------
   logic lat_valid = 1'b0;
   int   lat_done  = 0;
   for (genvar gi = 0; gi < 4; gi++) begin : g_lat
      localparam int LR = 1 << gi;
      sha256_stream_core_if lb();
      assign lb.blk_valid    = lat_valid;
      assign lb.blk_data     = ABC_BLK;
      assign lb.blk_first    = 1'b1;
      assign lb.blk_last     = 1'b1;
      assign lb.digest_ready = 1'b1;
`ifdef SHA256_STREAM_SHA224_EN
      assign lb.mode_224     = 1'b0;
`endif
      sha256_stream_core #(.ROUNDS_PER_CYCLE(LR)) u_lat (.clk(clk), .rst(rst), .s(lb));
      int   hs_c = -1;
      logic pv   = 1'b0;
      always @(negedge clk) begin
         if (!rst) begin
            if (lat_valid && lb.blk_ready) hs_c = cyc;
            if (lb.digest_valid && !pv) begin
               checks++;
               if ((cyc - hs_c) != (64 / LR + 2) || lb.digest !== ABC_D) begin
                  errors++;
                  $display("FAIL lat_r%0d: got %0d cycles digest %h, required %0d cycles digest %h",
                           LR, cyc - hs_c, lb.digest, 64 / LR + 2, ABC_D);
               end else begin
                  $display("[%0d] R=%0d abc digest after %0d cycles ok", cyc, LR, cyc - hs_c);
               end
               lat_done++;
            end
            pv = lb.digest_valid;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] ref_digest(input bl_t blks, input bit m224);
      logic [31:0] hh [8];
      logic [31:0] w  [64];
      logic [31:0] v  [8];
      logic [31:0] t1, t2, s0, s1;
      blk_t b;
      if (m224) hh = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                       32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
      else      hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      for (int k = 0; k < blks.size(); k++) begin
         b = blks[k];
         for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
         for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
         end
         v = hh;
         for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) +
                 ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) +
                 ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
         end
         for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
      end
      return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], m224 ? 32'h0 : hh[7]};
   endfunction

   function automatic bq_t str_bytes(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic bl_t pad(input bq_t msg);
      bq_t b;
      bl_t o;
      blk_t blk;
      longint unsigned bits;
      b = msg;
      bits = 64'(msg.size()) * 8;
      b.push_back(8'h80);
      while (b.size() % 64 != 56) b.push_back(8'h00);
      for (int i = 7; i >= 0; i--) b.push_back(8'(bits >> (8 * i)));
      for (int k = 0; k < b.size() / 64; k++) begin
         blk = '0;
         for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = b[64*k + j];
         o.push_back(blk);
      end
      return o;
   endfunction

   // ---------------- scoreboard monitor ----------------
   logic [255:0] exp_q [$];
   int   hs_last = 0;
   logic dv_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         dv_prev = 1'b0;
      end else begin
         if (bus.digest_valid && !dv_prev) begin
            checks++;
            if ((cyc - hs_last) != LAT) begin
               errors++;
               $display("FAIL digest_latency: got %0d cycles, required %0d", cyc - hs_last, LAT);
            end
         end
         if (bus.digest_valid && bus.digest_ready) begin
            logic [255:0] e;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_digest: got %h, required no digest", bus.digest);
            end else begin
               e = exp_q.pop_front();
               if (bus.digest !== e) begin
                  errors++;
                  $display("FAIL digest: got %h, required %h", bus.digest, e);
               end else begin
                  $display("[%0d] digest %h ok", cyc, bus.digest);
               end
            end
         end
         dv_prev = bus.digest_valid;
      end
   end

   // ---------------- stimulus ----------------
   // Tasks start and end just after a rising edge.
   task automatic send_block(input blk_t d, input bit f, input bit l, output int hs);
      int n;
      n = 0;
      bus.blk_data  = d;
      bus.blk_first = f;
      bus.blk_last  = l;
`ifdef SHA256_STREAM_SHA224_EN
      bus.mode_224  = mode_sel;
`endif
      bus.blk_valid = 1'b1;
      @(negedge clk);
      while (!bus.blk_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      hs = cyc;
      if (!bus.blk_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: blk_ready=0 after %0d cycles, required 1", n);
         hs = -1;
      end
      @(posedge clk);
      #1;
      bus.blk_valid = 1'b0;
      if (hs >= 0) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.blk_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept: busy=%b blk_ready=%b, required busy=1 blk_ready=0",
                     bus.busy, bus.blk_ready);
         end
      end
   endtask

   task automatic send_msg(input bl_t blks, input logic [255:0] expd);
      int hs, prev_hs;
      prev_hs = -1;
      for (int i = 0; i < blks.size(); i++) begin
         send_block(blks[i], i == 0, i == blks.size() - 1, hs);
         if (i > 0 && prev_hs >= 0 && hs >= 0) begin
            checks++;
            if (hs - prev_hs != LAT) begin
               errors++;
               $display("FAIL chain_rate: got %0d cycles between blocks, required %0d", hs - prev_hs, LAT);
            end
         end
         prev_hs = hs;
      end
      hs_last = prev_hs;
      exp_q.push_back(expd);
      $display("[%0d] sent message of %0d blocks, expect %h", cyc, blks.size(), expd);
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (bus.blk_ready !== 1'b1 || bus.digest_valid !== 1'b0 || bus.digest !== 256'h0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s: blk_ready=%b digest_valid=%b busy=%b digest=%h, required 1 0 0 and zero",
                  tag, bus.blk_ready, bus.digest_valid, bus.busy, bus.digest);
      end else begin
         $display("[%0d] %s outputs ok", cyc, tag);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d digests outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bl_t  blks;
      bq_t  msg;
      int   n, hs;
      bus.blk_valid = 1'b0;
      bus.blk_data  = '0;
      bus.blk_first = 1'b0;
      bus.blk_last  = 1'b0;
`ifdef SHA256_STREAM_SHA224_EN
      bus.mode_224  = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_values");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // latency for every legal R
      lat_valid = 1'b1;
      @(posedge clk);
      #1;
      lat_valid = 1'b0;
      n = 0;
      while (lat_done < 4 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (lat_done < 4) begin
         checks++;
         errors++;
         $display("FAIL lat_timeout: %0d instances finished, required 4", lat_done);
      end

      // known vectors
      send_msg(pad(str_bytes("abc")), ABC_D);
      msg.delete();
      send_msg(pad(msg), EMPTY_D);
      send_msg(pad(str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq")), TWO_D);
`ifdef SHA256_STREAM_SHA224_EN
      mode_sel = 1'b1;
      send_msg(pad(str_bytes("abc")), ABC224_D);
      mode_sel = 1'b0;
      send_msg(pad(str_bytes("abc")), ABC_D);
`endif
      wait_drain();

      // back-pressure: digest held, pending block not taken
      dr_mode = 1;
      send_msg(pad(str_bytes("abc")), ABC_D);
      n = 0;
      @(negedge clk);
      while (!bus.digest_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      bus.blk_data  = EMPTY_BLK;
      bus.blk_first = 1'b1;
      bus.blk_last  = 1'b1;
      bus.blk_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.blk_ready !== 1'b0 || bus.digest_valid !== 1'b1 || bus.digest !== ABC_D) begin
            errors++;
            $display("FAIL hold_%0d: blk_ready=%b digest_valid=%b digest=%h, required 0 1 %h",
                     i, bus.blk_ready, bus.digest_valid, bus.digest, ABC_D);
         end
         @(negedge clk);
      end
      dr_mode = 0;
      @(negedge clk);
      checks++;
      if (bus.blk_ready !== 1'b0 || bus.digest_ready !== 1'b1) begin
         errors++;
         $display("FAIL take_cycle: blk_ready=%b digest_ready=%b, required 0 1", bus.blk_ready, bus.digest_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.blk_ready !== 1'b1 || bus.digest_valid !== 1'b0 || bus.digest !== ABC_D) begin
         errors++;
         $display("FAIL after_take: blk_ready=%b digest_valid=%b digest=%h, required 1 0 %h",
                  bus.blk_ready, bus.digest_valid, bus.digest, ABC_D);
      end
      hs_last = cyc;
      exp_q.push_back(EMPTY_D);
      $display("[%0d] pending block accepted after digest transfer", cyc);
      @(posedge clk);
      #1;
      bus.blk_valid = 1'b0;
      wait_drain();

      // reset in the middle of ROUND aborts the message
      send_msg(pad(str_bytes("abc")), ABC_D);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_round_reset");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_msg(pad(str_bytes("abc")), ABC_D);
      wait_drain();

      // randomized messages against the model, random consumer stalls
      dr_mode = 2;
      for (int m = 0; m < 8; m++) begin
         msg.delete();
         n = $urandom_range(0, 150);
         for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
`ifdef SHA256_STREAM_SHA224_EN
         mode_sel = 1'($urandom_range(0, 1));
`endif
         blks = pad(msg);
         send_msg(blks, ref_digest(blks, mode_sel));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      hs = 0;
      wait_drain();
      dr_mode = 0;
      mode_sel = 1'b0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
